// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync, blanking, pixel strobe, addresses and a sync delay line.
// Define VGA_TEST_PATTERN_EN to drive eight vertical colour bars on pattern_rgb.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned SYNC_DLY = 0,
  localparam int unsigned ColW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int unsigned RowW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            pix_en,
  output logic            HS,
  output logic            VS,
  output logic            blank,
  output logic            hblank,
  output logic            vblank,
  output logic            line_start,
  output logic            frame_start,
  output logic [ColW-1:0] col,
  output logic [RowW-1:0] row,
  output logic [23:0]     pattern_rgb
);

  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW   = (HTot > 1) ? $clog2(HTot) : 1;
  localparam int unsigned VW   = (VTot > 1) ? $clog2(VTot) : 1;
  localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HLast   = HW'(HTot - 1);
  localparam logic [VW-1:0] VLast   = VW'(VTot - 1);

  // One extra bit so a sync window ending exactly at the line total still fits.
  localparam logic [HW:0] HActEnd  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HSyncBeg = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HSyncEnd = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] VActEnd  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VSyncBeg = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VSyncEnd = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // Bundle order: {HS, VS, blank, hblank, vblank}.
  localparam logic [4:0] SyncIdle = {~HS_POL, ~VS_POL, 3'b111};

  logic [DW-1:0]   div_q, div_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [4:0]      sync_q, sync_d;
  logic            pix_en_q, pix_en_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  logic       tick;
  logic [HW:0] hx;
  logic [VW:0] vx;
  logic       hblank_c, vblank_c, blank_c, hsync_c, vsync_c;
  logic [4:0] sync_cur, sync_out;

  always_comb begin
    tick = en && (div_q == DivLast);
    div_d = div_q;
    if (en) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end

    hx       = {1'b0, h_q};
    vx       = {1'b0, v_q};
    hblank_c = hx >= HActEnd;
    vblank_c = vx >= VActEnd;
    blank_c  = hblank_c | vblank_c;
    hsync_c  = (hx >= HSyncBeg) && (hx < HSyncEnd);
    vsync_c  = (vx >= VSyncBeg) && (vx < VSyncEnd);
    sync_cur = {hsync_c ? HS_POL : ~HS_POL, vsync_c ? VS_POL : ~VS_POL,
                blank_c, hblank_c, vblank_c};

    pix_en_d      = tick;
    line_start_d  = tick && (h_q == '0);
    frame_start_d = tick && (h_q == '0) && (v_q == '0);

    sync_d = sync_q;
    col_d  = col_q;
    row_d  = row_q;
    if (tick) begin
      sync_d = sync_out;
      if (!blank_c) begin
        col_d = h_q[ColW-1:0];
        row_d = v_q[RowW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      sync_q        <= SyncIdle;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      sync_q        <= sync_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      col_q         <= col_d;
      row_q         <= row_d;
    end
  end

  // Sync/blank shift register, advanced only on pixel ticks.
  if (SYNC_DLY == 0) begin : g_no_dly
    assign sync_out = sync_cur;
  end else begin : g_dly
    logic [4:0] dly_q [SYNC_DLY];
    logic [4:0] dly_d [SYNC_DLY];

    always_comb begin
      for (int i = 0; i < int'(SYNC_DLY); i++) begin
        dly_d[i] = dly_q[i];
      end
      if (tick) begin
        dly_d[0] = sync_cur;
        for (int i = 1; i < int'(SYNC_DLY); i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < int'(SYNC_DLY); i++) begin
        if (reset) begin
          dly_q[i] <= SyncIdle;
        end else begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    assign sync_out = dly_q[SYNC_DLY-1];
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] rgb_q, rgb_d;
  logic [2:0]  bar;

  always_comb begin
    bar   = 3'((32'(h_q) * 32'd8) / 32'(H_ACTIVE));
    rgb_d = rgb_q;
    if (tick) begin
      rgb_d = blank_c ? 24'h0 : {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 24'h0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign pattern_rgb = rgb_q;
`else
  assign pattern_rgb = 24'h0;
`endif

  assign pix_en      = pix_en_q;
  assign HS          = sync_q[4];
  assign VS          = sync_q[3];
  assign blank       = sync_q[2];
  assign hblank      = sync_q[1];
  assign vblank      = sync_q[0];
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign col         = col_q;
  assign row         = row_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four vga_timing_gen configurations against a position-arithmetic model.
module tb_vga_timing_gen;

  localparam int NDUT = 4;
  // d0: small mode; d1: small mode + 3-pixel sync delay; d2: small, div 3, positive sync; d3: defaults.
  localparam int P_HA [NDUT] = '{8, 8, 8, 640};
  localparam int P_HF [NDUT] = '{2, 2, 2, 16};
  localparam int P_HS [NDUT] = '{3, 3, 3, 96};
  localparam int P_HB [NDUT] = '{1, 1, 1, 48};
  localparam int P_VA [NDUT] = '{4, 4, 4, 480};
  localparam int P_VF [NDUT] = '{1, 1, 1, 10};
  localparam int P_VS [NDUT] = '{1, 1, 1, 2};
  localparam int P_VB [NDUT] = '{1, 1, 1, 33};
  localparam int P_CD [NDUT] = '{1, 1, 3, 4};
  localparam int P_HP [NDUT] = '{0, 0, 1, 0};
  localparam int P_VP [NDUT] = '{0, 0, 1, 0};
  localparam int P_DL [NDUT] = '{0, 3, 2, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  // Observed outputs, flags = {pix_en, HS, VS, blank, hblank, vblank, line_start, frame_start}.
  logic [7:0]  obs_fl  [NDUT];
  logic [15:0] obs_col [NDUT];
  logic [15:0] obs_row [NDUT];
  logic [23:0] obs_rgb [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CW = (P_HA[g] > 1) ? $clog2(P_HA[g]) : 1;
    localparam int RW = (P_VA[g] > 1) ? $clog2(P_VA[g]) : 1;
    logic pe, hs, vs, bl, hb, vb, ls, fs;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic [23:0] rgb;

    vga_timing_gen #(
      .H_ACTIVE(P_HA[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
      .V_ACTIVE(P_VA[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g]),
      .CLK_DIV(P_CD[g]), .HS_POL(P_HP[g] != 0), .VS_POL(P_VP[g] != 0), .SYNC_DLY(P_DL[g])
    ) u_dut (
      .clk(clk), .reset(reset), .en(en), .pix_en(pe), .HS(hs), .VS(vs), .blank(bl),
      .hblank(hb), .vblank(vb), .line_start(ls), .frame_start(fs), .col(c), .row(r),
      .pattern_rgb(rgb)
    );

    assign obs_fl[g]  = {pe, hs, vs, bl, hb, vb, ls, fs};
    assign obs_col[g] = 16'(c);
    assign obs_row[g] = 16'(r);
    assign obs_rgb[g] = rgb;
  end

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: enabled cycles and pixel ticks since reset, plus expected outputs.
  longint      m_e [NDUT];
  longint      m_t [NDUT];
  logic [7:0]  x_fl  [NDUT];
  logic [15:0] x_col [NDUT];
  logic [15:0] x_row [NDUT];
  logic [23:0] x_rgb [NDUT];

  task automatic chk(input string tag, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL d%0d_%s actual=0x%0h required=0x%0h", i, tag, act, exp);
    end
  endtask

  function automatic int tot_h(input int i);
    return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
  endfunction

  function automatic int tot_v(input int i);
    return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
  endfunction

  // {HS, VS, blank, hblank, vblank} for the k-th pixel since reset; negative k is the idle fill.
  function automatic logic [4:0] sync_at(input int i, input longint k);
    logic hp, vp, hb, vb, hsy, vsy;
    int h, v;
    hp = (P_HP[i] != 0);
    vp = (P_VP[i] != 0);
    if (k < 0) return {~hp, ~vp, 3'b111};
    h   = int'(k % tot_h(i));
    v   = int'((k / tot_h(i)) % tot_v(i));
    hb  = h >= P_HA[i];
    vb  = v >= P_VA[i];
    hsy = (h >= P_HA[i] + P_HF[i]) && (h < P_HA[i] + P_HF[i] + P_HS[i]);
    vsy = (v >= P_VA[i] + P_VF[i]) && (v < P_VA[i] + P_VF[i] + P_VS[i]);
    return {hsy ? hp : ~hp, vsy ? vp : ~vp, hb | vb, hb, vb};
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [23:0] bar_rgb(input int i, input int h);
    int b;
    b = (h * 8) / P_HA[i];
    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction
`endif

  task automatic model_step(input int i, input logic rst, input logic e);
    logic tick;
    longint k;
    int h, v;
    if (rst) begin
      m_e[i]   = 0;
      m_t[i]   = 0;
      x_fl[i]  = {1'b0, sync_at(i, -1), 2'b00};
      x_col[i] = 16'h0;
      x_row[i] = 16'h0;
      x_rgb[i] = 24'h0;
    end else begin
      tick = e && ((m_e[i] % P_CD[i]) == P_CD[i] - 1);
      if (e) m_e[i]++;
      x_fl[i][7] = tick;
      x_fl[i][1] = 1'b0;
      x_fl[i][0] = 1'b0;
      if (tick) begin
        k = m_t[i];
        h = int'(k % tot_h(i));
        v = int'((k / tot_h(i)) % tot_v(i));
        x_fl[i][1]   = (h == 0);
        x_fl[i][0]   = (h == 0) && (v == 0);
        x_fl[i][6:2] = sync_at(i, k - P_DL[i]);
        x_rgb[i] = 24'h0;
        if (h < P_HA[i] && v < P_VA[i]) begin
          x_col[i] = 16'(h);
          x_row[i] = 16'(v);
`ifdef VGA_TEST_PATTERN_EN
          x_rgb[i] = bar_rgb(i, h);
`endif
        end
        m_t[i]++;
      end
    end
  endtask

  task automatic step(input logic rst, input logic e);
    reset = rst;
    en    = e;
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      model_step(i, rst, e);
      chk("flags", i, obs_fl[i], x_fl[i]);
      chk("col", i, obs_col[i], x_col[i]);
      chk("row", i, obs_row[i], x_row[i]);
      chk("rgb", i, obs_rgb[i], x_rgb[i]);
    end
  endtask

  int first_pe3 = -1, ls3_a = -1, ls3_b = -1, hs0_fall = -1, hs1_fall = -1;
  int vs0_low = 0, hs0_low_l1 = 0, fs0_second = -1, gap_pe = 0, ls_gap = -1;
  logic fs3_first = 1'b0, ls3_first = 1'b0;
  longint col0_c5 = -1, col0_c8 = -1, col0_c14 = -1, col0_resume = -1;

  initial begin
    // Reset state.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_flags", 3, obs_fl[3], 8'h7C);
    chk("reset_flags", 2, obs_fl[2], 8'h1C);
    chk("reset_col", 3, obs_col[3], 0);

    // Free run from reset: latency, sync placement, line and frame periods.
    for (int c = 1; c <= 3300; c++) begin
      step(1'b0, 1'b1);
      if (obs_fl[3][7] && first_pe3 < 0) begin
        first_pe3 = c;
        fs3_first = obs_fl[3][0];
        ls3_first = obs_fl[3][1];
      end
      if (obs_fl[3][1]) begin
        if (ls3_a < 0) ls3_a = c;
        else if (ls3_b < 0) ls3_b = c;
      end
      if (!obs_fl[0][6] && hs0_fall < 0) hs0_fall = c;
      if (!obs_fl[1][6] && hs1_fall < 0) hs1_fall = c;
      if (c <= 14 && !obs_fl[0][6]) hs0_low_l1++;
      if (c <= 98 && !obs_fl[0][5]) vs0_low++;
      if (c > 1 && obs_fl[0][0] && fs0_second < 0) fs0_second = c;
      if (c == 5) col0_c5 = obs_col[0];
      if (c == 8) col0_c8 = obs_col[0];
      if (c == 14) col0_c14 = obs_col[0];
    end
    chk("first_pix_en_clk", 3, first_pe3, 4);
    chk("first_frame_start", 3, fs3_first, 1);
    chk("first_line_start", 3, ls3_first, 1);
    chk("line_period", 3, ls3_b - ls3_a, 3200);
    chk("hs_fall_clk", 0, hs0_fall, 11);
    chk("hs_low_count", 0, hs0_low_l1, 3);
    chk("hs_fall_clk_dly3", 1, hs1_fall, 14);
    chk("vs_low_ticks", 0, vs0_low, 14);
    chk("col_k4", 0, col0_c5, 4);
    chk("col_k7", 0, col0_c8, 7);
    chk("col_hold_k13", 0, col0_c14, 7);
    chk("second_frame_clk", 0, fs0_second, 99);

    // Enable gap of 10 clks at h=5.
    step(1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) step(1'b0, 1'b1);
    for (int c = 6; c <= 15; c++) begin
      step(1'b0, 1'b0);
      for (int i = 0; i < NDUT; i++) gap_pe += int'(obs_fl[i][7]);
    end
    for (int c = 16; c <= 40; c++) begin
      step(1'b0, 1'b1);
      if (c == 16) col0_resume = obs_col[0];
      if (obs_fl[0][1] && ls_gap < 0) ls_gap = c;
    end
    chk("gap_pix_en", 0, gap_pe, 0);
    chk("gap_resume_col", 0, col0_resume, 5);
    chk("gap_next_line_clk", 0, ls_gap, 25);

    // Mid-frame reset at v=3, h=6.
    step(1'b1, 1'b1);
    for (int c = 1; c <= 48; c++) step(1'b0, 1'b1);
    chk("pre_reset_col", 0, obs_col[0], 5);
    chk("pre_reset_row", 0, obs_row[0], 3);
    step(1'b1, 1'b1);
    chk("midreset_flags", 0, obs_fl[0], 8'h7C);
    chk("midreset_col", 0, obs_col[0], 0);
    chk("midreset_row", 0, obs_row[0], 0);
    step(1'b0, 1'b1);
    chk("restart_flags", 0, obs_fl[0], 8'hE3);

    // Random enable with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0);
    end

`ifdef VGA_TEST_PATTERN_EN
    step(1'b1, 1'b1);
    for (int c = 1; c <= 2564; c++) begin
      step(1'b0, 1'b1);
      if (c == 4) chk("rgb_col0", 3, obs_rgb[3], 24'h000000);
      if (c == 324) chk("rgb_col80", 3, obs_rgb[3], 24'h0000FF);
      if (c == 2560) chk("rgb_col639", 3, obs_rgb[3], 24'hFFFFFF);
      if (c == 2564) chk("rgb_blank", 3, obs_rgb[3], 24'h000000);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates HS/VS, blanking flags, a pixel strobe, and row/col addresses for any video mode, with configurable clock divide and sync polarity.
- Adds frame/line start pulses, a run enable, and a programmable sync/blank delay line that aligns timing outputs with downstream tile/sprite pipeline latency.
- Sits between the system clock domain logic and the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, system clocks per pixel (>=1)
HS_POL, 0, HS active level (0 = active-low)
VS_POL, 0, VS active level
SYNC_DLY, 0, pixel ticks of delay on HS/VS/blank/hblank/vblank (0..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  run enable; when 0, all counters hold
pix_en  out  1  one-clk pixel strobe, every CLK_DIV clks while en=1
HS  out  1  horizontal sync at HS_POL level
VS  out  1  vertical sync at VS_POL level
blank  out  1  1 outside the active area
hblank  out  1  1 when horizontal position is not active
vblank  out  1  1 when vertical position is not active
line_start  out  1  pulse on the tick entering h=0
frame_start  out  1  pulse on the tick entering h=0, v=0
col  out  $clog2(H_ACTIVE)  active column; holds its last value in blanking
row  out  $clog2(V_ACTIVE)  active row; holds its last value in blanking
pattern_rgb  out  24  test-pattern pixel {R,G,B}

Behaviour:
- Divider: div counts 0..CLK_DIV-1 while en=1 and wraps. tick = en && div==CLK_DIV-1. pix_en is registered tick, one clk late. With CLK_DIV=1, tick=en.
- Counters: h in 0..H_TOT-1, where H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP. v in 0..V_TOT-1, defined the same way. Both advance only on tick.
  - h wraps to 0 at H_TOT-1; v increments on that wrap.
  - At v=V_TOT-1 with an h wrap, v wraps to 0.
- Line order: active -> front porch -> sync -> back porch.
  - Sync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Vertical is the same.
  - hblank = h>=H_ACTIVE. vblank = v>=V_ACTIVE. blank = hblank|vblank.
- Registered outputs: all outputs are registered and update in the clk after tick, aligned with pix_en.
  - col=h and row=v while active; otherwise they hold.
  - line_start and frame_start are 1-clk pulses coincident with pix_en.
- Delay line: HS, VS, blank, hblank and vblank pass through a SYNC_DLY-deep shift register advanced on tick.
  - col, row, line_start, frame_start and pix_en are never delayed, so addresses lead the sync signals by SYNC_DLY pixels.
  - SYNC_DLY=0 means no added stage.
- en=0: div, h, v and the delay line hold. pix_en, line_start and frame_start stay 0. Other outputs hold.
- Reset, including mid-frame: within one clk, div=h=v=0 and the delay line is filled with the inactive/blanked value.
  - Output values: HS=~HS_POL, VS=~VS_POL, blank=hblank=vblank=1, col=row=0, pulses=0, pattern_rgb=0.
  - First pix_en comes CLK_DIV clks after reset deasserts (en=1). frame_start and line_start both pulse with that first pix_en.
- Simultaneous h and v wrap: a single tick produces frame_start and line_start together.
- Width rule: h and v are wide enough for H_TOT-1 and V_TOT-1. Comparisons are unsigned with no truncation.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: pattern_rgb is eight vertical colour bars, bar index = (col*8)/H_ACTIVE.
  - Bar colour bits = {index[2],index[1],index[0]}; each bit expands to 8'hFF or 8'h00 in R,G,B order.
  - pattern_rgb is forced to 0 when undelayed blank=1.
  - It is registered with col, so it has zero lead relative to col.
- Undefined: pattern_rgb is tied to 24'h0 and no pattern logic is synthesised.

Test Plan:
- Defaults, CLK_DIV=4, reset released -> first pix_en at clk 4; frame_start=line_start=1 with it; period between line_start pulses = 3200 clks; between frame_start pulses = 3200*525 clks.
- Small mode H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=1, polarity 0 -> HS=0 exactly at h=10..12; VS=0 for the 14 ticks of v=5; col runs 0..7, then holds at 7 during blanking.
- Same mode, SYNC_DLY=3 -> HS, VS and blank edges occur exactly 3 pix_en after the SYNC_DLY=0 run; col and row are identical between the two runs.
- en deasserted for 10 clks at h=5 -> no pix_en during the gap; h resumes at 5; the line is 10 clks longer and all other timing is unchanged.
- Reset asserted at v=3, h=6 -> next clk HS=1, VS=1, blank=1, col=row=0; sequence then restarts exactly as from power-up.
- VGA_TEST_PATTERN_EN defined, defaults -> col=0 gives 24'h000000, col=80 gives 24'h0000FF, col=639 gives 24'hFFFFFF; blanked pixels give 0.
